// File: rtl/cpu_pkg.sv
// Shared definitions for the fetch path: default bus widths, the NOP
// encoding decode sees when the prefetch queue is empty, and the layout of
// one queued fetch entry (PC in the upper bits, instruction in the lower).
package cpu_pkg;

  localparam int DEFAULT_ADDR_W  = 16;
  localparam int DEFAULT_INSTR_W = 16;

  localparam logic [DEFAULT_INSTR_W-1:0] NOP_INSTR = 16'h0000;

  typedef struct packed {
    logic [DEFAULT_ADDR_W-1:0]  pc;
    logic [DEFAULT_INSTR_W-1:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/prefetch_fifo.sv
// Synchronous FIFO that buffers fetched {pc, instr} entries for decode.
//
// Ports:
//   clk        rising-edge clock
//   reset      synchronous active-high reset, empties the queue
//   flush      synchronous flush, priority over push and pop
//   push       write push_data at the tail
//   push_data  entry to write
//   pop        drop the head entry
//   head_valid queue holds at least one entry
//   head_data  entry at the head (raw storage; caller masks when empty)
//   count      number of entries held, 0..DEPTH
module prefetch_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     flush,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic                     head_valid,
  output logic [WIDTH-1:0]         head_data,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic [CNT_W-1:0] cnt;

  logic do_push;
  logic do_pop;

  // Flush and reset both dominate; pop is only meaningful with data present.
  assign do_push = push & ~flush;
  assign do_pop  = pop & ~flush & (cnt != '0);

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

  // Storage needs no reset; validity is tracked by cnt.
  always_ff @(posedge clk) begin
    if (!reset && do_push) mem[wr_ptr] <= push_data;
  end

  assign head_valid = (cnt != '0);
  assign head_data  = mem[rd_ptr];
  assign count      = cnt;

  // The producer throttles itself so a push can never land on a full queue.
  no_overflow: assert property (@(posedge clk) disable iff (reset)
    !(do_push && cnt == CNT_W'(DEPTH)));

endmodule

// File: rtl/fetch_prefetch_unit.sv
// Fetch front end: owns the fetch PC, issues reads to a 1-cycle-latency
// synchronous ROM, and queues returned instructions with their PCs so that
// decode stalls are absorbed without refetching. A redirect flushes the
// queue and discards the read that is still in flight.
//
// Ports:
//   clk              rising-edge clock
//   reset            synchronous active-high reset
//   rom_en           read request issued this cycle
//   rom_address      ROM read address (current fetch PC)
//   rom_q            ROM data, valid the cycle after a request
//   redirect         branch taken: flush and refetch from redirect_target
//   redirect_target  new fetch address
//   stall            decode cannot accept the head this cycle
//   instr_valid      queue head valid
//   instr            queue head instruction, NOP when empty
//   instr_pc         PC of the queue head, 0 when empty
//   count            entries currently queued
module fetch_prefetch_unit
  import cpu_pkg::*;
#(
  parameter int                ADDR_W   = DEFAULT_ADDR_W,
  parameter int                INSTR_W  = DEFAULT_INSTR_W,
  parameter int                DEPTH    = 4,
  parameter int                PC_STEP  = 1,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic                   clk,
  input  logic                   reset,
  output logic                   rom_en,
  output logic [ADDR_W-1:0]      rom_address,
  input  logic [INSTR_W-1:0]     rom_q,
  input  logic                   redirect,
  input  logic [ADDR_W-1:0]      redirect_target,
  input  logic                   stall,
  output logic                   instr_valid,
  output logic [INSTR_W-1:0]     instr,
  output logic [ADDR_W-1:0]      instr_pc,
  output logic [$clog2(DEPTH):0] count
);

  localparam int CNT_W   = $clog2(DEPTH) + 1;
  localparam int ENTRY_W = ADDR_W + INSTR_W;

  logic [ADDR_W-1:0]  fetch_pc;
  logic               inflight;
  logic [ADDR_W-1:0]  inflight_pc;

  logic               push;
  logic               pop;
  logic               head_valid;
  logic [ENTRY_W-1:0] head_data;
  logic [CNT_W-1:0]   fifo_count;
  logic [CNT_W:0]     occupancy;

  assign pop  = head_valid & ~stall;
  assign push = inflight & ~redirect;

  // Slots already spoken for after this cycle: queued entries plus the read
  // in flight, less the one decode takes now. Issuing only while this is
  // below DEPTH guarantees the returning data always has a slot.
  assign occupancy = {1'b0, fifo_count} + (CNT_W+1)'(inflight) - (CNT_W+1)'(pop);
  assign rom_en    = ~reset & ~redirect & (occupancy < (CNT_W+1)'(DEPTH));

  assign rom_address = fetch_pc;

  // PC and in-flight tracking. A cycle without issue clears inflight, so a
  // stale rom_q after reset or redirect is never captured.
  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_pc    <= RESET_PC;
      inflight    <= 1'b0;
      inflight_pc <= '0;
    end else if (redirect) begin
      fetch_pc    <= redirect_target;
      inflight    <= 1'b0;
    end else if (rom_en) begin
      inflight    <= 1'b1;
      inflight_pc <= fetch_pc;
      fetch_pc    <= fetch_pc + ADDR_W'(PC_STEP);
    end else begin
      inflight    <= 1'b0;
    end
  end

  prefetch_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk        (clk),
    .reset      (reset),
    .flush      (redirect),
    .push       (push),
    .push_data  ({inflight_pc, rom_q}),
    .pop        (pop),
    .head_valid (head_valid),
    .head_data  (head_data),
    .count      (fifo_count)
  );

  // Empty queue presents a NOP at PC 0 so decode needs no separate bubble path.
  assign instr_valid = head_valid;
  assign instr       = head_valid ? head_data[INSTR_W-1:0] : INSTR_W'(NOP_INSTR);
  assign instr_pc    = head_valid ? head_data[ENTRY_W-1:INSTR_W] : '0;
  assign count       = fifo_count;

endmodule

// File: tb/tb_fetch_prefetch_unit.sv
// Directed bench for fetch_prefetch_unit: a main instance with RESET_PC 0
// and a second instance with RESET_PC 16'hFFFE for the PC wrap case. Each
// instance has its own synchronous ROM returning 16'h1000 + address.
module tb_fetch_prefetch_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        redirect = 1'b0;
  logic [15:0] redirect_target = '0;
  logic        stall = 1'b0;
  logic        rom_en;
  logic [15:0] rom_address;
  logic [15:0] rom_q = '0;
  logic        instr_valid;
  logic [15:0] instr;
  logic [15:0] instr_pc;
  logic [2:0]  count;

  logic        reset2 = 1'b1;
  logic        rom_en2;
  logic [15:0] rom_address2;
  logic [15:0] rom_q2 = '0;
  logic        instr_valid2;
  logic [15:0] instr2;
  logic [15:0] instr_pc2;
  logic [2:0]  count2;

  int n_compared   = 0;
  int n_mismatched = 0;

  always #5 clk = ~clk;

  // Synchronous ROM models, one-cycle read latency
  always @(posedge clk) if (rom_en)  rom_q  <= 16'h1000 + rom_address;
  always @(posedge clk) if (rom_en2) rom_q2 <= 16'h1000 + rom_address2;

  fetch_prefetch_unit #(
    .ADDR_W(16), .INSTR_W(16), .DEPTH(4), .PC_STEP(1), .RESET_PC(16'h0000)
  ) u_dut (
    .clk(clk), .reset(reset), .rom_en(rom_en), .rom_address(rom_address),
    .rom_q(rom_q), .redirect(redirect), .redirect_target(redirect_target),
    .stall(stall), .instr_valid(instr_valid), .instr(instr),
    .instr_pc(instr_pc), .count(count)
  );

  fetch_prefetch_unit #(
    .ADDR_W(16), .INSTR_W(16), .DEPTH(4), .PC_STEP(1), .RESET_PC(16'hFFFE)
  ) u_dut_wrap (
    .clk(clk), .reset(reset2), .rom_en(rom_en2), .rom_address(rom_address2),
    .rom_q(rom_q2), .redirect(1'b0), .redirect_target(16'h0000),
    .stall(1'b0), .instr_valid(instr_valid2), .instr(instr2),
    .instr_pc(instr_pc2), .count(count2)
  );

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic applyStimulus(input logic r, input logic s,
                               input logic rd, input logic [15:0] tgt);
    reset           = r;
    stall           = s;
    redirect        = rd;
    redirect_target = tgt;
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    n_compared++;
    assert (observed === expected) else begin
      n_mismatched++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    // Reset state
    applyStimulus(1, 0, 0, 16'h0);
    tick(); tick();
    applyStimulus(1, 0, 0, 16'h0);
    checkOutput("rst_valid", 32'(instr_valid), 32'd0);
    checkOutput("rst_instr", 32'(instr), 32'd0);
    checkOutput("rst_pc", 32'(instr_pc), 32'd0);
    checkOutput("rst_count", 32'(count), 32'd0);
    checkOutput("rst_rom_en", 32'(rom_en), 32'd0);

    // 1: streaming after reset release
    tick(); applyStimulus(0, 0, 0, 16'h0);
    checkOutput("t1_c0_rom_en", 32'(rom_en), 32'd1);
    checkOutput("t1_c0_addr", 32'(rom_address), 32'h0);
    checkOutput("t1_c0_valid", 32'(instr_valid), 32'd0);
    tick(); applyStimulus(0, 0, 0, 16'h0);
    checkOutput("t1_c1_valid", 32'(instr_valid), 32'd0);
    checkOutput("t1_c1_addr", 32'(rom_address), 32'h1);
    for (int i = 0; i < 6; i++) begin
      tick(); applyStimulus(0, 0, 0, 16'h0);
      checkOutput("t1_valid", 32'(instr_valid), 32'd1);
      checkOutput("t1_pc", 32'(instr_pc), 32'(i));
      checkOutput("t1_instr", 32'(instr), 32'h1000 + 32'(i));
    end
    checkOutput("t1_count", 32'(count), 32'd1);

    // 2: stall for 10 cycles, queue fills and issue stops
    for (int i = 0; i < 10; i++) begin
      tick(); applyStimulus(0, 1, 0, 16'h0);
      checkOutput("t2_hold_pc", 32'(instr_pc), 32'h6);
    end
    checkOutput("t2_count_full", 32'(count), 32'd4);
    checkOutput("t2_rom_en_off", 32'(rom_en), 32'd0);
    for (int k = 0; k < 6; k++) begin
      tick(); applyStimulus(0, 0, 0, 16'h0);
      checkOutput("t2_resume_pc", 32'(instr_pc), 32'h6 + 32'(k));
      checkOutput("t2_resume_instr", 32'(instr), 32'h1006 + 32'(k));
    end

    // 3: redirect with three queued and one in flight
    tick(); applyStimulus(0, 0, 1, 16'h0040);
    checkOutput("t3_pre_count", 32'(count), 32'd3);
    checkOutput("t3_pre_pc", 32'(instr_pc), 32'hC);
    checkOutput("t3_redir_rom_en", 32'(rom_en), 32'd0);
    tick(); applyStimulus(0, 0, 0, 16'h0);
    checkOutput("t3_flush_count", 32'(count), 32'd0);
    checkOutput("t3_flush_valid", 32'(instr_valid), 32'd0);
    checkOutput("t3_flush_instr", 32'(instr), 32'd0);
    checkOutput("t3_flush_pc", 32'(instr_pc), 32'd0);
    checkOutput("t3_rom_en", 32'(rom_en), 32'd1);
    checkOutput("t3_addr", 32'(rom_address), 32'h40);
    tick(); applyStimulus(0, 0, 0, 16'h0);
    checkOutput("t3_gap_valid", 32'(instr_valid), 32'd0);
    for (int k = 0; k < 3; k++) begin
      tick(); applyStimulus(0, 0, 0, 16'h0);
      checkOutput("t3_pc", 32'(instr_pc), 32'h40 + 32'(k));
      checkOutput("t3_instr", 32'(instr), 32'h1040 + 32'(k));
    end

    // 4: redirect, stall and pending push together
    tick(); applyStimulus(0, 1, 1, 16'h0080);
    checkOutput("t4_pre_pc", 32'(instr_pc), 32'h43);
    checkOutput("t4_pre_count", 32'(count), 32'd1);
    tick(); applyStimulus(0, 0, 0, 16'h0);
    checkOutput("t4_count", 32'(count), 32'd0);
    checkOutput("t4_valid", 32'(instr_valid), 32'd0);
    checkOutput("t4_rom_en", 32'(rom_en), 32'd1);
    checkOutput("t4_addr", 32'(rom_address), 32'h80);
    tick(); applyStimulus(0, 0, 0, 16'h0);
    checkOutput("t4_gap_count", 32'(count), 32'd0);
    checkOutput("t4_gap_valid", 32'(instr_valid), 32'd0);
    tick(); applyStimulus(0, 0, 0, 16'h0);
    checkOutput("t4_pc", 32'(instr_pc), 32'h80);
    checkOutput("t4_instr", 32'(instr), 32'h1080);

    // 6: one-cycle reset with two queued and one in flight
    tick(); applyStimulus(0, 1, 0, 16'h0);
    checkOutput("t6_pre_pc", 32'(instr_pc), 32'h81);
    tick(); applyStimulus(1, 0, 0, 16'h0);
    checkOutput("t6_pre_count", 32'(count), 32'd2);
    checkOutput("t6_rst_rom_en", 32'(rom_en), 32'd0);
    tick(); applyStimulus(0, 0, 0, 16'h0);
    checkOutput("t6_count", 32'(count), 32'd0);
    checkOutput("t6_instr", 32'(instr), 32'd0);
    checkOutput("t6_valid", 32'(instr_valid), 32'd0);
    checkOutput("t6_pc", 32'(instr_pc), 32'd0);
    checkOutput("t6_rom_en", 32'(rom_en), 32'd1);
    checkOutput("t6_addr", 32'(rom_address), 32'h0);
    tick(); applyStimulus(0, 0, 0, 16'h0);
    checkOutput("t6_stale_count", 32'(count), 32'd0);
    checkOutput("t6_stale_valid", 32'(instr_valid), 32'd0);
    tick(); applyStimulus(0, 0, 0, 16'h0);
    checkOutput("t6_restart_valid", 32'(instr_valid), 32'd1);
    checkOutput("t6_restart_pc", 32'(instr_pc), 32'h0);
    checkOutput("t6_restart_instr", 32'(instr), 32'h1000);

    // 5: RESET_PC near the top of the address space wraps to zero
    tick(); reset2 = 1'b0; #1;
    checkOutput("t5_rom_en", 32'(rom_en2), 32'd1);
    checkOutput("t5_addr", 32'(rom_address2), 32'hFFFE);
    tick();
    checkOutput("t5_gap_valid", 32'(instr_valid2), 32'd0);
    for (int k = 0; k < 8; k++) begin
      logic [15:0] exp_pc;
      logic [15:0] exp_instr;
      exp_pc    = 16'hFFFE + 16'(k);
      exp_instr = 16'h1000 + exp_pc;
      tick();
      checkOutput("t5_valid", 32'(instr_valid2), 32'd1);
      checkOutput("t5_pc", 32'(instr_pc2), 32'(exp_pc));
      checkOutput("t5_instr", 32'(instr2), 32'(exp_instr));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule

// File: doc/fetch_prefetch_unit.md
Name: fetch_prefetch_unit

Overview:
Parametrised successor to the discrete PC register / PC adder / PC mux / FetchDecode register fetch path. It owns the fetch PC and issues reads to the synchronous ROM, which has 1-cycle latency. Returned instructions are buffered with their PCs in a DEPTH-entry prefetch queue that feeds decode. Decode stalls are absorbed without re-fetching, and a branch redirect flushes the queue and discards the in-flight read.

Parameters:
ADDR_W, 16, PC and ROM address width
INSTR_W, 16, instruction width
DEPTH, 4, prefetch queue entries; power of 2, >= 2
PC_STEP, 1, PC increment per fetched instruction
RESET_PC, 0, first fetch address after reset

Ports:
clk  in  1  clock; all state updates on rising edge
reset  in  1  synchronous, active-high reset
rom_en  out  1  read request issued this cycle
rom_address  out  ADDR_W  ROM read address (= fetch_pc)
rom_q  in  INSTR_W  ROM data; valid the cycle after a request
redirect  in  1  branch taken; flush and refetch
redirect_target  in  ADDR_W  new fetch address
stall  in  1  decode cannot accept (hazard NOP)
instr_valid  out  1  queue head valid
instr  out  INSTR_W  queue head instruction; NOP (all zero) when empty
instr_pc  out  ADDR_W  PC of queue head; 0 when empty
count  out  $clog2(DEPTH)+1  entries currently queued

Behaviour:
- State: fetch_pc; inflight bit plus inflight_pc; queue with rd_ptr, wr_ptr and count.
- Reset (sync, priority over everything):
  - fetch_pc = RESET_PC, inflight = 0, queue empty.
  - Outputs: instr_valid = 0, instr = 0, instr_pc = 0, count = 0, rom_en = 0 during reset.
- Pop: pop = instr_valid & ~stall.
- Push: push = inflight & ~redirect. The entry written is {inflight_pc, rom_q}.
- Issue: rom_en = ~reset & ~redirect & ((count + inflight - pop) < DEPTH).
  - On issue: inflight <= 1, inflight_pc <= fetch_pc, fetch_pc <= fetch_pc + PC_STEP (mod 2^ADDR_W).
  - Otherwise: inflight <= 0.
- Latency:
  - A request in cycle N is visible at the queue head in cycle N+2.
  - First instr_valid is the 2nd cycle after reset deasserts.
  - Sustained throughput is 1 instruction per cycle with stall = 0.
- Full: the queue never overflows. Issue is throttled so that count + inflight never exceeds DEPTH. A push into a full queue is impossible by construction and is guarded by an assertion.
- Empty: instr_valid = 0; instr and instr_pc are driven 0, so decode sees a NOP.
- Simultaneous push and pop: count is unchanged; both pointers advance.
- Redirect (priority over push, pop and issue):
  - Next cycle: queue empty, count = 0, inflight = 0, fetch_pc = redirect_target.
  - rom_q returned in the redirect cycle is discarded.
  - The first request to redirect_target is issued the cycle after redirect; it appears at the head 2 cycles later.
- Redirect with stall = 1: redirect still flushes; stall only gates pop.
- Pointer wrap: rd_ptr and wr_ptr wrap modulo DEPTH. fetch_pc wraps modulo 2^ADDR_W with no flag.
- Reset mid-operation: the inflight read is dropped, and the rom_q of the following cycle is ignored because inflight = 0.
- All outputs except rom_en and rom_address are registered or decoded directly from registered queue state. There is no combinational path from rom_q to instr.

Decomposition:
- cpu_pkg:
  - fetch_entry_t struct {pc, instr} sized by package widths.
  - NOP_INSTR = 16'h0000.
  - Default ADDR_W and INSTR_W constants.
- Sub-module prefetch_fifo:
  - Parametrised synchronous FIFO (WIDTH, DEPTH) with push, pop, flush, count and head outputs.
  - Flush is synchronous and has priority over push and pop.
- fetch_prefetch_unit contains the PC, issue and inflight logic and instantiates prefetch_fifo.

Test Plan:
1. Release reset, stall = 0, ROM[a] = 16'h1000 + a -> instr_valid first high 2 cycles after reset low. instr_pc = 0, 1, 2, ... with instr = 16'h1000 + pc on consecutive cycles, with no gaps.
2. Hold stall = 1 for 10 cycles from steady state -> count saturates at 4 and rom_en goes 0 with count + inflight = 4. Release stall -> the next instr_pc values are consecutive, with no duplicate or skipped PC.
3. Redirect to 16'h0040 with count = 3 and inflight = 1 -> next cycle count = 0 and instr_valid = 0. rom_address = 16'h0040 with rom_en = 1 one cycle after redirect; instr_pc = 16'h0040 two cycles later. No pre-redirect PC ever appears after the flush.
4. Redirect, stall and a pending push in the same cycle -> redirect wins: count = 0, nothing pushed, fetch_pc = target.
5. RESET_PC = 16'hFFFE -> instr_pc sequence FFFE, FFFF, 0000, 0001. Queue pointers wrap after 4 pushes with correct ordering.
6. Assert reset for 1 cycle while a read is in flight and count = 2 -> after reset: count = 0, instr = 0, and the stale rom_q is not queued. Fetch restarts at RESET_PC with first instr_valid 2 cycles later.
